// File: rtl/cordic_gain_comp_pkg.sv
// Shared CORDIC definitions: Q2.30 word format, gain constant and the
// round/negate/saturate helper used by the output stage.
package cordic_gain_comp_pkg;

    localparam int unsigned WORD_W       = 32;
    localparam int unsigned CORDIC_FRAC  = 30;
    localparam int unsigned CORDIC_ITERS = 30;
    localparam logic [WORD_W-1:0] CORDIC_K = 32'h26DD3B6A;

    typedef logic signed [WORD_W-1:0] q2_30_t;

    typedef struct packed {
        q2_30_t x;
        q2_30_t y;
    } xy_t;

    // Round half-up, optional negate, clamp to the signed 32-bit range
    function automatic q2_30_t round_neg_sat(input logic signed [2*WORD_W-1:0] p,
                                             input logic                       neg,
                                             input int unsigned                frac);
        logic signed [2*WORD_W-1:0] r;
        r = (p + (64'sd1 <<< (frac - 1))) >>> frac;
        if (neg) begin
            r = -r;
        end
        if (r > 64'sd2147483647) begin
            r = 64'sd2147483647;
        end else if (r < -64'sd2147483648) begin
            r = -64'sd2147483648;
        end
        return q2_30_t'(r[WORD_W-1:0]);
    endfunction

endpackage

// File: rtl/cordic_out_fifo.sv
// First-word-fall-through FIFO for compensated results. Drops on push while
// full without a pop and records that in a sticky drop flag.
module cordic_out_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves on the same edge
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            drop   <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (push && !do_push) begin
                drop <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_gain_comp.sv
// CORDIC output stage: multiply by the gain constant, round/negate/saturate,
// then buffer into a small FWFT FIFO that absorbs consumer backpressure.
module cordic_gain_comp
    import cordic_gain_comp_pkg::*;
#(
    parameter int unsigned       DEPTH = 4,
    parameter int unsigned       FRAC  = CORDIC_FRAC,
    parameter logic [WORD_W-1:0] K     = CORDIC_K
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [WORD_W-1:0]      x_in,
    input  logic [WORD_W-1:0]      y_in,
    input  logic                   neg,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [WORD_W-1:0]      x_out,
    output logic [WORD_W-1:0]      y_out,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    localparam int unsigned PW = 2 * WORD_W;

    logic signed [PW-1:0] p_x;
    logic signed [PW-1:0] p_y;
    logic                 neg1;
    logic                 v1;
    xy_t                  res;
    logic                 v2;
    xy_t                  head;
    logic                 fifo_full;
    logic                 fifo_empty;

    // S1: full-precision products against the unsigned gain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_x  <= '0;
            p_y  <= '0;
            neg1 <= 1'b0;
            v1   <= 1'b0;
        end else begin
            p_x  <= PW'($signed(x_in)) * PW'($signed({1'b0, K}));
            p_y  <= PW'($signed(y_in)) * PW'($signed({1'b0, K}));
            neg1 <= neg;
            v1   <= in_valid;
        end
    end

    // S2: back to Q2.30 with sign correction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res <= '0;
            v2  <= 1'b0;
        end else begin
            res.x <= round_neg_sat(p_x, neg1, FRAC);
            res.y <= round_neg_sat(p_y, neg1, FRAC);
            v2    <= v1;
        end
    end

    cordic_out_fifo #(
        .DEPTH (DEPTH),
        .W     (PW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (v2),
        .pop   (out_ready),
        .wdata (res),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level),
        .drop  (overflow)
    );

    assign out_valid = !fifo_empty;
    assign x_out     = head.x;
    assign y_out     = head.y;

endmodule

// File: doc/cordic_gain_comp.md
# cordic_gain_comp

Output stage of the pipelined CORDIC rotator. It sits directly downstream of the last shift-accumulate iteration stage and consumes its x/y results. It removes the CORDIC gain by multiplying by K ≈ 0.6072529350 and applies the sign correction requested by the upstream pre-rotation. Results land in a small first-word-fall-through output FIFO with a ready/valid interface. The iteration pipeline cannot stall, so backpressure is absorbed by the FIFO, and any loss is flagged.

## Interface
- `DEPTH`, 4, output FIFO entries; power of two, ≥ 2.
- `FRAC`, 30, fractional bits of the x/y format (Q2.30) and of `K`.
- `K`, 652032874 (0x26DD3B6A), CORDIC gain compensation, unsigned Q2.30.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  x_in/y_in/neg valid this cycle, from the valid tag travelling alongside the iteration stages.
- `x_in`  in  32  signed Q2.30, final-stage x.
- `y_in`  in  32  signed Q2.30, final-stage y.
- `neg`  in  1  negate both results (upstream pre-rotated by π).
- `out_ready`  in  1  consumer accepts the head entry.
- `out_valid`  out  1  FIFO non-empty.
- `x_out`  out  32  signed Q2.30, compensated x at FIFO head.
- `y_out`  out  32  signed Q2.30, compensated y at FIFO head.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky; set when a result was dropped.

## Operation
- **S1 (multiply):** register `p_x = $signed(x_in) * $signed({1'b0,K})` and the matching `p_y`, both 64-bit signed. Also register `neg` and `v1 = in_valid`.
- **S2 (round/negate/saturate):**
  - Round half-up: `r = (p + 2^(FRAC-1)) >>> FRAC`.
  - If `neg`, `r = -r`.
  - Saturate to the 32-bit signed range, −2^31..2^31−1. Negating −2^31 yields 0x7FFFFFFF.
  - Register the result with `v2 = v1`.
- **Push:** a FIFO push occurs on each edge where `v2 = 1`.
- **Pop:** a pop occurs when `out_valid && out_ready`.
- **FIFO:**
  - Circular buffer with read/write pointers one bit wider than the index, so full and empty are distinguishable.
  - First-word-fall-through: `x_out`/`y_out` show the head entry combinationally from the buffer.
  - When empty, the outputs show the last read location; this value is don't-care and must not be checked.
- **Boundaries:**
  - Push while full with no pop: the result is dropped, `overflow` ← 1, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both are performed, `level` stays DEPTH, and `overflow` is unchanged.
  - Push and pop in the same cycle while non-empty and not full: `level` is unchanged.
  - Pop while empty: impossible, because `out_valid = 0`.
  - Pointers wrap modulo 2·DEPTH.
- **Overflow clear:** `overflow` is cleared only by `rst`.
- **Reset mid-operation:** S1/S2 valids, pointers, `level` and `overflow` are cleared immediately. In-flight and buffered results are lost.

## Timing
- **Reset values:** `out_valid` 0, `level` 0, `overflow` 0. `x_out`/`y_out` are 0, because the buffer storage is reset.
- **Latency:** a sample with `in_valid` at edge N is written at edge N+2. From that point `out_valid` = 1 (when previously empty) and the sample is poppable in the same cycle.
- **Throughput:** one sample per cycle with no bubbles when `out_ready` is held at 1.
- **Ordering:** `level` and `out_valid` change only on clock edges. Output order is strictly input order.

## Structure
- Shared CORDIC package holds:
  - the `K` constant;
  - the `FRAC` width;
  - a typedef for the 32-bit signed Q2.30 word;
  - the iteration count, which upstream uses to size the valid-tag delay line.
- The FIFO is a natural sub-module, `cordic_out_fifo`, parameterised by `DEPTH` and word width (64 bits: {x, y}). It exposes `push`, `pop`, `full`, `empty`, `level`, and `drop`, which drives `overflow`.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → `out_valid` = 0, `level` = 0, `overflow` = 0 immediately, with no dependence on `clk`.
- **Unit gain:** `x_in` = 0x40000000, `y_in` = 0, `neg` = 0, `out_ready` = 1 → two edges later `out_valid` = 1, `x_out` = 0x26DD3B6A, `y_out` = 0.
- **Negate and saturate:**
  - Same input with `neg` = 1 → `x_out` = 0xD922C496.
  - `x_in` = 0x7FFFFFFF, `neg` = 1 → `x_out` = −round(K·(2^31−1)/2^30), not wrapped.
- **Rounding:** `x_in` = 1 → `x_out` = 1; `x_in` = −1 → `x_out` = −1; `x_in` = 0 → `x_out` = 0.
- **Backpressure:** `out_ready` = 0, six consecutive valid samples A–F → `level` = 4, `overflow` = 1 from the edge E is written. Then `out_ready` = 1 → A, B, C, D are popped in order, then `out_valid` = 0.
- **Full with simultaneous pop:** FIFO full, `out_ready` = 1, and a new sample arrives each cycle → `level` stays 4, no drops, `overflow` stays 0, order is preserved.
